// File: rtl/qc_circular_unshifter.sv
// Iterative inverse circular shifter: rotates a sub-block LEFT by shift_val inside a
// runtime lifting size z_val, applying at most ROTATES_PER_CYCLE positions per clock.
`timescale 1ns/1ps
module qc_circular_unshifter #(
    parameter int MAXZ              = 81,
    parameter int ROTATES_PER_CYCLE = 4,
    parameter int SW                = $clog2(MAXZ),
    parameter int ZW                = $clog2(MAXZ + 1)
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            valid_in,
    output logic            in_ready,
    input  logic [MAXZ-1:0] in_data,
    input  logic [SW-1:0]   shift_val,
    input  logic [ZW-1:0]   z_val,
    output logic            valid_out,
    input  logic            out_ready,
    output logic [MAXZ-1:0] out_data,
    output logic            out_err,
    output logic            busy
);

    if (ROTATES_PER_CYCLE < 1 || ROTATES_PER_CYCLE >= MAXZ) begin : g_bad_rpc
        $fatal(1, "qc_circular_unshifter: ROTATES_PER_CYCLE must be in 1..MAXZ-1");
    end

    localparam logic [SW-1:0] RPC = SW'(ROTATES_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [MAXZ-1:0] data_q,  data_d;
    logic [ZW-1:0]   z_q,     z_d;
    logic [SW-1:0]   rem_q,   rem_d;
    logic            err_q,   err_d;

    logic            accept;
    logic            illegal_in;
    logic [SW-1:0]   step;
    logic [SW-1:0]   rem_after;

    function automatic logic [MAXZ-1:0] mask_to_z(input logic [MAXZ-1:0] d,
                                                  input logic [ZW-1:0]   z);
        logic [MAXZ-1:0] m;
        m = '0;
        for (int i = 0; i < MAXZ; i++) begin
            if (i < int'(z)) begin
                m[i] = d[i];
            end
        end
        return m;
    endfunction

    // Left rotation modulo the runtime z: bit i moves to (i+step) mod z, bits >= z stay 0.
    // Callers guarantee step < z <= MAXZ.
    function automatic logic [MAXZ-1:0] rotl_in_z(input logic [MAXZ-1:0] d,
                                                  input logic [ZW-1:0]   z,
                                                  input logic [SW-1:0]   s);
        logic [MAXZ-1:0] r;
        int              src;
        r = '0;
        for (int j = 0; j < MAXZ; j++) begin
            if (j < int'(z)) begin
                src  = (j >= int'(s)) ? (j - int'(s)) : (j - int'(s) + int'(z));
                r[j] = d[src[SW-1:0]];
            end
        end
        return r;
    endfunction

    assign illegal_in = (z_val == '0) || (int'(z_val) > MAXZ) ||
                        (int'(shift_val) >= int'(z_val));

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = valid_in && in_ready;
    assign valid_out = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;
    assign out_err   = err_q;

    assign step      = (rem_q < RPC) ? rem_q : RPC;
    assign rem_after = rem_q - step;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        z_d     = z_q;
        rem_d   = rem_q;
        err_d   = err_q;

        case (state_q)
            ROTATE: begin
                data_d = rotl_in_z(data_q, z_q, step);
                rem_d  = rem_after;
                if (rem_after == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase

        // A new beat can only be taken in IDLE or in DONE at handoff, so it overrides the above.
        if (accept) begin
            z_d = z_val;
            if (illegal_in) begin
                data_d  = '0;
                err_d   = 1'b1;
                rem_d   = '0;
                state_d = DONE;
            end else begin
                data_d  = mask_to_z(in_data, z_val);
                err_d   = 1'b0;
                rem_d   = shift_val;
                state_d = (shift_val == '0) ? DONE : ROTATE;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            z_q     <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            z_q     <= z_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_qc_circular_unshifter.sv
// Directed bench for qc_circular_unshifter (MAXZ=81, ROTATES_PER_CYCLE=4).
`timescale 1ns/1ps
module tb_qc_circular_unshifter;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        in_ready;
    logic [80:0] in_data;
    logic [6:0]  shift_val;
    logic [6:0]  z_val;
    logic        valid_out;
    logic        out_ready;
    logic [80:0] out_data;
    logic        out_err;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 CLK = ~CLK;

    qc_circular_unshifter #(
        .MAXZ(81),
        .ROTATES_PER_CYCLE(4)
    ) dut (
        .CLK(CLK),
        .rst_n(rst_n),
        .valid_in(valid_in),
        .in_ready(in_ready),
        .in_data(in_data),
        .shift_val(shift_val),
        .z_val(z_val),
        .valid_out(valid_out),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_err(out_err),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [80:0] rotr(input logic [80:0] d, input int s, input int z);
        logic [80:0] r;
        r = '0;
        for (int i = 0; i < z; i++) r[i] = d[(i + s) % z];
        return r;
    endfunction

    task automatic send(input logic [80:0] d, input logic [6:0] s, input logic [6:0] z);
        int n;
        n = 0;
        @(negedge CLK);
        valid_in = 1'b1; in_data = d; shift_val = s; z_val = z;
        while (!in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        valid_in = 1'b0; in_data = '1; shift_val = 7'h55; z_val = 7'd0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!valid_out && lat < 100);
    endtask

    task automatic pop();
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [80:0] d, input logic [6:0] s,
                        input logic [6:0] z, input logic [80:0] exp_d, input logic exp_err,
                        input int exp_lat);
        int lat;
        send(d, s, z);
        wait_out(lat);
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_data"}, 128'(out_data), 128'(exp_d));
        chk({tag, "_err"}, 128'(out_err), 128'(exp_err));
        pop();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [80:0] pat;
        logic [95:0] rnd;
        logic [80:0] orig;
        logic [6:0]  rs;
        int          lat;
        int          seen;

        pat = 81'h1_5A5A_F00F_1234_5678_9ABC;
        rst_n = 1'b0; valid_in = 1'b0; out_ready = 1'b0;
        in_data = '0; shift_val = '0; z_val = '0;
        repeat (2) @(negedge CLK);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_valid_out", 128'(valid_out), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_err", 128'(out_err), 128'(0));
        rst_n = 1'b1;

        // Basic directed rotations inside z=8
        beat("z8_s3", 81'h01, 7'd3, 7'd8, 81'h08, 1'b0, 2);
        beat("z8_wrap", 81'h81, 7'd1, 7'd8, 81'h03, 1'b0, 2);
        beat("z8_s4", 81'h01, 7'd4, 7'd8, 81'h10, 1'b0, 2);
        beat("z8_s5", 81'h01, 7'd5, 7'd8, 81'h20, 1'b0, 3);

        // Boundaries
        beat("s0_pass", pat, 7'd0, 7'd81, pat, 1'b0, 1);
        beat("z1_s0", 81'h3, 7'd0, 7'd1, 81'h1, 1'b0, 1);
        beat("z81_s80", pat, 7'd80, 7'd81, {pat[0], pat[80:1]}, 1'b0, 21);
        beat("z40_mask", '1, 7'd7, 7'd40, 81'h00FF_FFFF_FFFF, 1'b0, 3);

        // Illegal inputs, then a legal one
        beat("ill_s_eq_z", 81'hFF, 7'd8, 7'd8, 81'h0, 1'b1, 1);
        beat("ill_z0", 81'hFF, 7'd0, 7'd0, 81'h0, 1'b1, 1);
        beat("ill_z90", 81'hFF, 7'd3, 7'd90, 81'h0, 1'b1, 1);
        beat("legal_after", 81'h01, 7'd2, 7'd8, 81'h04, 1'b0, 2);

        // Round trip through a bench-side right rotation
        for (int k = 0; k < 20; k++) begin
            rnd  = {$urandom, $urandom, $urandom};
            orig = rnd[80:0];
            rs   = 7'($urandom_range(0, 80));
            beat("roundtrip", rotr(orig, int'(rs), 81), rs, 7'd81, orig, 1'b0,
                 1 + (int'(rs) + 3) / 4);
        end

        // Backpressure: DONE held while upstream keeps offering a beat
        send(81'h0F, 7'd2, 7'd8);
        wait_out(lat);
        chk("bp_lat", 128'(lat), 128'(2));
        valid_in = 1'b1; in_data = 81'h1FF; shift_val = 7'd1; z_val = 7'd8;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("bp_valid", 128'(valid_out), 128'(1));
            chk("bp_data", 128'(out_data), 128'h3C);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_data = 81'h55; shift_val = 7'd0; z_val = 7'd8; out_ready = 1'b1;
        #1;
        chk("bp_handoff_ready", 128'(in_ready), 128'(1));
        @(posedge CLK);
        #1;
        valid_in = 1'b0; out_ready = 1'b0; in_data = '1;
        @(negedge CLK);
        chk("b2b_s0_valid", 128'(valid_out), 128'(1));
        chk("b2b_s0_data", 128'(out_data), 128'h55);
        chk("b2b_s0_err", 128'(out_err), 128'(0));
        valid_in = 1'b1; in_data = 81'h01; shift_val = 7'd4; z_val = 7'd8; out_ready = 1'b1;
        @(posedge CLK);
        #1;
        valid_in = 1'b0; out_ready = 1'b0; in_data = '1;
        @(negedge CLK);
        chk("b2b_s4_gap", 128'(valid_out), 128'(0));
        @(negedge CLK);
        chk("b2b_s4_valid", 128'(valid_out), 128'(1));
        chk("b2b_s4_data", 128'(out_data), 128'h10);
        pop();

        // Asynchronous reset in the middle of a long rotation
        send(pat, 7'd80, 7'd81);
        repeat (5) @(negedge CLK);
        chk("mid_busy", 128'(busy), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_valid", 128'(valid_out), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_data", 128'(out_data), 128'(0));
        @(negedge CLK);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge CLK);
            if (valid_out) seen++;
        end
        chk("no_stale_valid", 128'(seen), 128'(0));
        beat("post_rst", 81'h81, 7'd1, 7'd8, 81'h03, 1'b0, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
